// File: rtl/alu_shift_sequencer_if.sv
// alu_shift_sequencer_if: command, ALU-drive and response bundle for the ALU shift sequencer.
// slave = sequencer view, master = issue logic / ALU / response consumer view.
`default_nettype none

interface alu_shift_sequencer_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [31:0] cmd_a_i;
  logic [31:0] cmd_b_i;
  logic        cmd_cin_i;
  logic [3:0]  cmd_sel_i;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_cin_o;
  logic [3:0]  alu_sel_o;
  logic [31:0] alu_f_i;
  logic        alu_cout_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_cout_o;
  logic        rsp_err_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_cin_i, cmd_sel_i,
    input  alu_f_i, alu_cout_i, rsp_ready_i,
    output cmd_ready_o, alu_a_o, alu_b_o, alu_cin_o, alu_sel_o,
    output rsp_valid_o, rsp_data_o, rsp_cout_o, rsp_err_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_cin_i, cmd_sel_i,
    output alu_f_i, alu_cout_i, rsp_ready_i,
    input  cmd_ready_o, alu_a_o, alu_b_o, alu_cin_o, alu_sel_o,
    input  rsp_valid_o, rsp_data_o, rsp_cout_o, rsp_err_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_shift_sequencer.sv
// ============================================================================
// Module  : alu_shift_sequencer
// Brief   : Drives a single-bit-shift ALU, building N-bit shifts by iteration.
//           Optional rotates enabled by defining ALU_SEQ_ROTATE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_shift_sequencer #(
  parameter int         SHAMT_W = 5,
  parameter logic [3:0] SEL_SHR = 4'b1000,
  parameter logic [3:0] SEL_SHL = 4'b1100
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  alu_shift_sequencer_if.slave  bus
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2:0]         r_op;
  logic [31:0]        r_acc;
  logic [31:0]        r_b;
  logic               r_cin;
  logic [3:0]         r_sel;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_cout;
  logic               r_err;

  logic               w_accept;
  logic               w_reserved;
  logic [SHAMT_W-1:0] w_passes;
  logic [31:0]        w_acc_run;

  assign w_accept = bus.cmd_valid_i && (r_state == S_IDLE);

  // Pass count decides whether RUN is entered at all; reserved ops never touch the ALU.
  always_comb begin
    w_reserved = 1'b0;
    w_passes   = '0;
    case (bus.cmd_op_i)
      OP_PASS:         w_passes = CNT_ONE;
      OP_SHR, OP_SHL:  w_passes = bus.cmd_b_i[SHAMT_W-1:0];
`ifdef ALU_SEQ_ROTATE_EN
      OP_ROR, OP_ROL:  w_passes = bus.cmd_b_i[SHAMT_W-1:0];
`endif
      default:         w_reserved = 1'b1;
    endcase
  end

  always_comb begin
    w_acc_run = bus.alu_f_i;
`ifdef ALU_SEQ_ROTATE_EN
    if (r_op == OP_ROR)
      w_acc_run = {r_acc[0], bus.alu_f_i[30:0]};
    else if (r_op == OP_ROL)
      w_acc_run = {bus.alu_f_i[31:1], r_acc[31]};
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_passes == '0) ? S_DONE : S_RUN;
      S_RUN:  if (r_cnt == CNT_ONE) w_state_nxt = S_DONE;
      S_DONE: if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready_o = (r_state == S_IDLE);
    bus.alu_a_o     = '0;
    bus.alu_b_o     = '0;
    bus.alu_cin_o   = 1'b0;
    bus.alu_sel_o   = '0;
    bus.rsp_valid_o = 1'b0;
    bus.rsp_data_o  = '0;
    bus.rsp_cout_o  = 1'b0;
    bus.rsp_err_o   = 1'b0;
    case (r_state)
      S_RUN: begin
        bus.alu_a_o = r_acc;
        if (r_op == OP_PASS) begin
          bus.alu_b_o   = r_b;
          bus.alu_cin_o = r_cin;
          bus.alu_sel_o = r_sel;
        end else begin
          bus.alu_sel_o = (r_op == OP_SHR || r_op == OP_ROR) ? SEL_SHR : SEL_SHL;
        end
      end
      S_DONE: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_data_o  = r_acc;
        bus.rsp_cout_o  = r_cout;
        bus.rsp_err_o   = r_err;
      end
      default: ;
    endcase
  end

  // RUN is only entered with a nonzero count, so the decrement cannot underflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op   <= '0;
      r_acc  <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_sel  <= '0;
      r_cnt  <= '0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= bus.cmd_op_i;
      r_acc  <= w_reserved ? 32'd0 : bus.cmd_a_i;
      r_b    <= bus.cmd_b_i;
      r_cin  <= bus.cmd_cin_i;
      r_sel  <= bus.cmd_sel_i;
      r_cnt  <= w_passes;
      r_cout <= 1'b0;
      r_err  <= w_reserved;
    end else if (r_state == S_RUN) begin
      r_acc  <= w_acc_run;
      r_cnt  <= r_cnt - CNT_ONE;
      r_cout <= (r_op == OP_PASS) ? bus.alu_cout_i : 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_sequencer.sv
// tb_alu_shift_sequencer: directed self-checking bench with a behavioural ALU model.
`default_nettype none

module tb_alu_shift_sequencer;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat;
  logic saw;
  logic [31:0] hold;

  alu_shift_sequencer_if bus();

  alu_shift_sequencer dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // ALU model: 0010 add-with-carry, 1000 shr1, 1100 shl1, otherwise xor.
  always_comb begin
    bus.alu_cout_i = 1'b0;
    case (bus.alu_sel_o)
      4'b0010: {bus.alu_cout_i, bus.alu_f_i} = {1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o} + 33'(bus.alu_cin_o);
      4'b1000: bus.alu_f_i = bus.alu_a_o >> 1;
      4'b1100: bus.alu_f_i = bus.alu_a_o << 1;
      default: bus.alu_f_i = bus.alu_a_o ^ bus.alu_b_o;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] sel);
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i = op; bus.cmd_a_i = a; bus.cmd_b_i = b;
    bus.cmd_cin_i = cin; bus.cmd_sel_i = sel;
    chk("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int l);
    l = 1;
    while (!bus.rsp_valid_o && l < 200) begin
      @(negedge clk_i);
      l++;
    end
    chk("rsp_timeout", 32'(bus.rsp_valid_o), 32'd1);
  endtask

  task automatic after_hs();
    @(negedge clk_i);
    chk("post_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("post_data",  bus.rsp_data_o, 32'd0);
    chk("post_ready", 32'(bus.cmd_ready_o), 32'd1);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = '0; bus.cmd_a_i = '0; bus.cmd_b_i = '0;
    bus.cmd_cin_i = 1'b0; bus.cmd_sel_i = '0; bus.rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_alu_a",     bus.alu_a_o, 32'd0);
    chk("rst_alu_sel",   32'(bus.alu_sel_o), 32'd0);
    rst_i = 1'b0;

    // 1: PASS through shl select
    issue(3'b000, 32'h8000_0001, 32'd0, 1'b0, 4'b1100);
    chk("t1_alu_sel", 32'(bus.alu_sel_o), 32'hC);
    chk("t1_alu_a",   bus.alu_a_o, 32'h8000_0001);
    wait_rsp(lat);
    chk("t1_lat",  lat, 32'd2);
    chk("t1_data", bus.rsp_data_o, 32'h0000_0002);
    chk("t1_cout", 32'(bus.rsp_cout_o), 32'd0);
    chk("t1_err",  32'(bus.rsp_err_o), 32'd0);
    after_hs();

    // PASS add with carry out
    issue(3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'b0010);
    chk("add_alu_b", bus.alu_b_o, 32'd1);
    wait_rsp(lat);
    chk("add_lat",  lat, 32'd2);
    chk("add_data", bus.rsp_data_o, 32'd0);
    chk("add_cout", 32'(bus.rsp_cout_o), 32'd1);
    after_hs();

    // PASS add with carry in
    issue(3'b000, 32'd5, 32'd7, 1'b1, 4'b0010);
    chk("addc_cin", 32'(bus.alu_cin_o), 32'd1);
    wait_rsp(lat);
    chk("addc_data", bus.rsp_data_o, 32'd13);
    chk("addc_cout", 32'(bus.rsp_cout_o), 32'd0);
    after_hs();

    // 2: SHR by 4
    issue(3'b001, 32'hF000_0000, 32'd4, 1'b1, 4'b0010);
    chk("t2_alu_sel", 32'(bus.alu_sel_o), 32'h8);
    chk("t2_alu_b",   bus.alu_b_o, 32'd0);
    chk("t2_alu_cin", 32'(bus.alu_cin_o), 32'd0);
    wait_rsp(lat);
    chk("t2_lat",  lat, 32'd5);
    chk("t2_data", bus.rsp_data_o, 32'h0F00_0000);
    chk("t2_cout", 32'(bus.rsp_cout_o), 32'd0);
    after_hs();

    // 3: SHL by 0
    issue(3'b010, 32'h1234_5678, 32'd0, 1'b0, 4'b0000);
    chk("t3_alu_sel", 32'(bus.alu_sel_o), 32'd0);
    wait_rsp(lat);
    chk("t3_lat",  lat, 32'd1);
    chk("t3_data", bus.rsp_data_o, 32'h1234_5678);
    chk("t3_err",  32'(bus.rsp_err_o), 32'd0);
    after_hs();

    // 4: SHL by 31 with response back-pressure, then back-to-back command
    bus.rsp_ready_i = 1'b0;
    issue(3'b010, 32'd1, 32'd31, 1'b0, 4'b0000);
    chk("t4_alu_sel", 32'(bus.alu_sel_o), 32'hC);
    wait_rsp(lat);
    chk("t4_lat",  lat, 32'd32);
    chk("t4_data", bus.rsp_data_o, 32'h8000_0000);
    hold = bus.rsp_data_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t4_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("t4_hold_data",  bus.rsp_data_o, 32'h8000_0000);
      chk("t4_hold_ready", 32'(bus.cmd_ready_o), 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i = 3'b000; bus.cmd_a_i = 32'h0000_0010; bus.cmd_b_i = 32'h0000_0003;
    bus.cmd_cin_i = 1'b0; bus.cmd_sel_i = 4'b0010;
    @(negedge clk_i);
    chk("t4_idle_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("t4_idle_valid", 32'(bus.rsp_valid_o), 32'd0);
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
    chk("t4_next_ready", 32'(bus.cmd_ready_o), 32'd0);
    wait_rsp(lat);
    chk("t4_next_lat",  lat, 32'd2);
    chk("t4_next_data", bus.rsp_data_o, 32'h0000_0013);
    after_hs();

    // 5: ROR by 1
    issue(3'b011, 32'd1, 32'd1, 1'b0, 4'b0000);
    wait_rsp(lat);
`ifdef ALU_SEQ_ROTATE_EN
    chk("t5_lat",  lat, 32'd2);
    chk("t5_data", bus.rsp_data_o, 32'h8000_0000);
    chk("t5_err",  32'(bus.rsp_err_o), 32'd0);
`else
    chk("t5_lat",  lat, 32'd1);
    chk("t5_data", bus.rsp_data_o, 32'd0);
    chk("t5_err",  32'(bus.rsp_err_o), 32'd1);
`endif
    after_hs();

    // reserved opcode
    issue(3'b111, 32'hDEAD_BEEF, 32'd3, 1'b1, 4'b0010);
    chk("rsv_alu_sel", 32'(bus.alu_sel_o), 32'd0);
    wait_rsp(lat);
    chk("rsv_lat",  lat, 32'd1);
    chk("rsv_data", bus.rsp_data_o, 32'd0);
    chk("rsv_cout", 32'(bus.rsp_cout_o), 32'd0);
    chk("rsv_err",  32'(bus.rsp_err_o), 32'd1);
    after_hs();

    // 6: reset during the third RUN cycle of SHR by 10
    issue(3'b001, 32'hFFFF_0000, 32'd10, 1'b0, 4'b0000);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("t6_running", 32'(bus.alu_sel_o), 32'h8);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("t6_rst_alu_a", bus.alu_a_o, 32'd0);
    chk("t6_rst_sel",   32'(bus.alu_sel_o), 32'd0);
    chk("t6_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (bus.rsp_valid_o) saw = 1'b1;
    end
    chk("t6_no_stale_rsp", 32'(saw), 32'd0);
    issue(3'b000, 32'h0000_0100, 32'h0000_0023, 1'b0, 4'b0010);
    wait_rsp(lat);
    chk("t6_pass_lat",  lat, 32'd2);
    chk("t6_pass_data", bus.rsp_data_o, 32'h0000_0123);
    after_hs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
